// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared definitions for the register-bank writeback scheduler.
//   DATA_W / ADDR_W : register width and register address width
//   REG_ZERO        : address of the hard-wired zero register
//   fifo_entry_t    : one buffered multi-cycle result {addr, data}
// -----------------------------------------------------------------------------
package regbank_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage : regbank_pkg

// File: rtl/regbank_sched_fifo.sv
// -----------------------------------------------------------------------------
// regbank_sched_fifo
// Small FIFO holding multi-cycle results until the shared write port is free.
// Push is ignored when full and pop is ignored when empty, so the caller may
// drive them from plain request terms.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_entry  : write one entry at the tail
//   pop               : drop the head entry
//   head              : current head entry (valid when !empty)
//   full, empty       : occupancy flags
//   count             : number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module regbank_sched_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  fifo_entry_t       push_entry,
    input  logic              pop,
    output fifo_entry_t       head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    fifo_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable gets its default at the top of an always_comb so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap by plain overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // NOTE: the storage array is deliberately not reset; count_q gates every
    // read, so stale contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule : regbank_sched_fifo

// File: rtl/regbank_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regbank_wb_scheduler
// Access controller for the 16 x 32-bit CPU register bank (reg0 reads zero).
//   - Scoreboard of destination registers owned by in-flight multi-cycle ops.
//   - Stalls decode on RAW/WAW hazards against those registers.
//   - Shares the single bank write port: pipeline writeback has fixed priority,
//     multi-cycle completions wait in a small FIFO.
//
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   id_*                         : decode slot (sources, destination, kind)
//   flush                        : pipeline flush; forwarded as rb_clear
//   wb_we/wb_addr/wb_data        : pipeline writeback, never stalled
//   mc_valid/mc_addr/mc_data     : multi-cycle result, handshake with mc_ready
//   stall_issue                  : decode must hold (also drives rb_hold)
//   rb_we/rb_addr_d/rb_data_d    : register bank write port
//   rb_hold/rb_clear             : register bank hold/clear
//
// Optional feature, enabled by defining REGBANK_SCHED_PERF_EN:
//   perf_stall_cycles   : saturating count of cycles with stall_issue=1
//   perf_port_conflicts : saturating count of cycles with wb_we=1 while the
//                         FIFO holds a result
// -----------------------------------------------------------------------------
module regbank_wb_scheduler
    import regbank_pkg::*;
#(
    parameter int DATA_W     = regbank_pkg::DATA_W,
    parameter int ADDR_W     = regbank_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2
`ifdef REGBANK_SCHED_PERF_EN
    ,
    parameter int PERF_W     = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_addr_a,
    input  logic [ADDR_W-1:0] id_addr_b,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_dst_we,
    input  logic              id_multicycle,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              stall_issue,
    output logic              rb_we,
    output logic [ADDR_W-1:0] rb_addr_d,
    output logic [DATA_W-1:0] rb_data_d,
    output logic              rb_hold,
    output logic              rb_clear
`ifdef REGBANK_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_port_conflicts
`endif
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;

    fifo_entry_t         fifo_push_entry;
    fifo_entry_t         fifo_head;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    logic                hazard;
    logic                sb_set;

    // ------------------------------------------------------------------
    // Hazard detection: purely from registered scoreboard state, so a bit
    // cleared by this cycle's pop still stalls this cycle.
    // ------------------------------------------------------------------
    assign hazard = id_valid &&
                    (pending_q[id_addr_a] || pending_q[id_addr_b] ||
                     (id_dst_we && pending_q[id_dst]));

    assign stall_issue = !reset && hazard;
    assign rb_hold     = stall_issue;
    assign rb_clear    = !reset && flush;

    assign sb_set = !reset && id_valid && !hazard && !flush &&
                    id_dst_we && id_multicycle && (id_dst != REG_ZERO);

    // ------------------------------------------------------------------
    // Multi-cycle result intake. mc_ready ignores a same-cycle pop, so a
    // full FIFO refuses the push even while it drains. Results for reg0
    // are acknowledged and dropped.
    // ------------------------------------------------------------------
    assign mc_ready        = !reset && !fifo_full;
    assign fifo_push       = mc_valid && mc_ready && (mc_addr != REG_ZERO);
    assign fifo_push_entry = '{addr: mc_addr, data: mc_data};

    regbank_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (fifo_push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // ------------------------------------------------------------------
    // Write-port arbitration: pipeline writeback first, then FIFO head.
    // The bank's own write-to-read bypass handles forwarding, so this is
    // a plain combinational mux.
    // ------------------------------------------------------------------
    always_comb begin
        rb_we     = 1'b0;
        rb_addr_d = '0;
        rb_data_d = '0;
        fifo_pop  = 1'b0;
        if (!reset) begin
            if (wb_we) begin
                rb_we     = 1'b1;
                rb_addr_d = wb_addr;
                rb_data_d = wb_data;
            end else if (!fifo_empty) begin
                rb_we     = 1'b1;
                rb_addr_d = fifo_head.addr;
                rb_data_d = fifo_head.data;
                fifo_pop  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. A set can never target the register being released in
    // the same cycle (that register is still pending, so the issue would
    // stall), so the order of clear and set below is immaterial.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) pending_d[fifo_head.addr] = 1'b0;
        if (sb_set)   pending_d[id_dst]         = 1'b1;
        pending_d[REG_ZERO] = 1'b0;
        if (reset) pending_d = '0;
    end

    always_ff @(posedge clk) begin
        pending_q <= pending_d;
    end

`ifdef REGBANK_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_stall_cycles_q,   perf_stall_cycles_d;
    logic [PERF_W-1:0] perf_port_conflicts_q, perf_port_conflicts_d;

    always_comb begin
        perf_stall_cycles_d   = perf_stall_cycles_q;
        perf_port_conflicts_d = perf_port_conflicts_q;
        if (stall_issue && !(&perf_stall_cycles_q))
            perf_stall_cycles_d = perf_stall_cycles_q + PERF_W'(1);
        if (!reset && wb_we && !fifo_empty && !(&perf_port_conflicts_q))
            perf_port_conflicts_d = perf_port_conflicts_q + PERF_W'(1);
        if (reset) begin
            perf_stall_cycles_d   = '0;
            perf_port_conflicts_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        perf_stall_cycles_q   <= perf_stall_cycles_d;
        perf_port_conflicts_q <= perf_port_conflicts_d;
    end

    assign perf_stall_cycles   = perf_stall_cycles_q;
    assign perf_port_conflicts = perf_port_conflicts_q;
`endif

`ifndef SYNTHESIS
    // The WAW stall keeps the pipeline from writing a register that a
    // multi-cycle op still owns; a write here means decode was bypassed.
    a_no_wb_to_pending : assert property (@(posedge clk) disable iff (reset)
        !(wb_we && pending_q[wb_addr]));

    a_fifo_count_bound : assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CNT_W'(FIFO_DEPTH));
`endif

endmodule : regbank_wb_scheduler

// File: tb/tb_regbank_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regbank_wb_scheduler
// Directed, table-driven bench: each record is one clock cycle of inputs and
// the outputs expected in that same cycle, followed by a hand-written
// sequence that waits (bounded) for a delayed multi-cycle write.
// -----------------------------------------------------------------------------
module tb_regbank_wb_scheduler;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct {
        logic          rst;
        logic          idv;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] dst;
        logic          dwe;
        logic          imc;
        logic          fl;
        logic          wbwe;
        logic [AW-1:0] wba;
        logic [DW-1:0] wbd;
        logic          mcv;
        logic [AW-1:0] mca;
        logic [DW-1:0] mcd;
        logic          e_rdy;
        logic          e_stall;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_clear;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_addr_a, id_addr_b, id_dst;
    logic          id_dst_we, id_multicycle, flush;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          mc_valid;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data;
    logic          mc_ready, stall_issue, rb_we, rb_hold, rb_clear;
    logic [AW-1:0] rb_addr_d;
    logic [DW-1:0] rb_data_d;
`ifdef REGBANK_SCHED_PERF_EN
    logic [31:0]   perf_stall_cycles, perf_port_conflicts;
`endif

    int applied     = 0;
    int miscompares = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    regbank_wb_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_addr_a     (id_addr_a),
        .id_addr_b     (id_addr_b),
        .id_dst        (id_dst),
        .id_dst_we     (id_dst_we),
        .id_multicycle (id_multicycle),
        .flush         (flush),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .mc_valid      (mc_valid),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .mc_ready      (mc_ready),
        .stall_issue   (stall_issue),
        .rb_we         (rb_we),
        .rb_addr_d     (rb_addr_d),
        .rb_data_d     (rb_data_d),
        .rb_hold       (rb_hold),
        .rb_clear      (rb_clear)
`ifdef REGBANK_SCHED_PERF_EN
        ,
        .perf_stall_cycles   (perf_stall_cycles),
        .perf_port_conflicts (perf_port_conflicts)
`endif
    );

    function automatic vec_t mk(
        input logic rst, input logic idv, input logic [AW-1:0] a,
        input logic [AW-1:0] b, input logic [AW-1:0] dst, input logic dwe,
        input logic imc, input logic fl,
        input logic wbwe, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
        input logic mcv, input logic [AW-1:0] mca, input logic [DW-1:0] mcd,
        input logic e_rdy, input logic e_stall, input logic e_we,
        input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data,
        input logic e_clear);
        vec_t v;
        v.rst = rst;   v.idv = idv;   v.a = a;       v.b = b;
        v.dst = dst;   v.dwe = dwe;   v.imc = imc;   v.fl = fl;
        v.wbwe = wbwe; v.wba = wba;   v.wbd = wbd;
        v.mcv = mcv;   v.mca = mca;   v.mcd = mcd;
        v.e_rdy = e_rdy;   v.e_stall = e_stall; v.e_we = e_we;
        v.e_addr = e_addr; v.e_data = e_data;   v.e_clear = e_clear;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset         = v.rst;
        id_valid      = v.idv;
        id_addr_a     = v.a;
        id_addr_b     = v.b;
        id_dst        = v.dst;
        id_dst_we     = v.dwe;
        id_multicycle = v.imc;
        flush         = v.fl;
        wb_we         = v.wbwe;
        wb_addr       = v.wba;
        wb_data       = v.wbd;
        mc_valid      = v.mcv;
        mc_addr       = v.mca;
        mc_data       = v.mcd;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        applied++;
        check({tag, ".mc_ready"},    DW'(mc_ready),    DW'(v.e_rdy));
        check({tag, ".stall_issue"}, DW'(stall_issue), DW'(v.e_stall));
        check({tag, ".rb_hold"},     DW'(rb_hold),     DW'(v.e_stall));
        check({tag, ".rb_we"},       DW'(rb_we),       DW'(v.e_we));
        check({tag, ".rb_addr_d"},   DW'(rb_addr_d),   DW'(v.e_addr));
        check({tag, ".rb_data_d"},   rb_data_d,        v.e_data);
        check({tag, ".rb_clear"},    DW'(rb_clear),    DW'(v.e_clear));
    endtask

    initial begin
        vec_t idle;
        bit   found;

        // Columns: rst | idv a b dst dwe imc fl | wbwe wba wbd | mcv mca mcd
        //          || rdy stall we addr data clear
        // Reset: outputs all zero even with every request active.
        vecs.push_back(mk(1, 0,0,0,0,0,0,0, 0,0,0,            0,0,0,             0,0,0,0,0,0));
        vecs.push_back(mk(1, 1,5,5,5,1,1,1, 1,2,32'h11,       1,5,32'hFF,        0,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        // RAW on multi-cycle dst 5; stall persists through the write cycle.
        vecs.push_back(mk(0, 1,1,2,5,1,1,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        vecs.push_back(mk(0, 1,5,0,6,1,0,0, 0,0,0,            0,0,0,             1,1,0,0,0,0));
        vecs.push_back(mk(0, 1,5,0,6,1,0,0, 0,0,0,            1,5,32'hDEADBEEF,  1,1,0,0,0,0));
        vecs.push_back(mk(0, 1,5,0,6,1,0,0, 0,0,0,            0,0,0,             1,1,1,5,32'hDEADBEEF,0));
        vecs.push_back(mk(0, 1,5,0,6,1,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        // wb beats mc in the same cycle; mc result written the cycle after.
        vecs.push_back(mk(0, 1,0,0,3,1,1,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 1,7,32'h77777777, 1,3,32'h33333333,  1,0,1,7,32'h77777777,0));
        vecs.push_back(mk(0, 1,0,3,0,0,0,0, 0,0,0,            0,0,0,             1,1,1,3,32'h33333333,0));
        vecs.push_back(mk(0, 1,0,3,0,0,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        // WAW stall only when the instruction actually writes its dst.
        vecs.push_back(mk(0, 1,0,0,8,1,1,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        vecs.push_back(mk(0, 1,0,0,8,1,0,0, 0,0,0,            0,0,0,             1,1,0,0,0,0));
        vecs.push_back(mk(0, 1,1,2,8,0,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        // wb held 4 cycles against 3 mc results; FIFO fills at 2.
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 1,1,32'hA1,       1,8,32'h88,        1,0,1,1,32'hA1,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 1,2,32'hA2,       1,9,32'h99,        1,0,1,2,32'hA2,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 1,1,32'hA3,       1,10,32'hAA,       0,0,1,1,32'hA3,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 1,2,32'hA4,       1,10,32'hAA,       0,0,1,2,32'hA4,0));
        // Full + pop: push still refused; then drain in order.
        vecs.push_back(mk(0, 1,8,0,0,0,0,0, 0,0,0,            1,10,32'hAA,       0,1,1,8,32'h88,0));
        vecs.push_back(mk(0, 1,8,0,0,0,0,0, 0,0,0,            1,10,32'hAA,       1,0,1,9,32'h99,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 0,0,0,            0,0,0,             1,0,1,10,32'hAA,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        // mc to reg0 is acked but takes no slot: FIFO fills after 2 more.
        vecs.push_back(mk(0, 1,0,0,4,1,1,0, 0,0,0,            1,0,32'h1234,      1,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 1,1,32'hB1,       1,11,32'hBB,       1,0,1,1,32'hB1,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 1,2,32'hB2,       1,12,32'hCC,       1,0,1,2,32'hB2,0));
        vecs.push_back(mk(0, 1,4,0,0,0,0,0, 1,1,32'hB3,       1,13,32'hDD,       0,1,1,1,32'hB3,0));
        // Reset with FIFO full and pending[4] set: everything dropped.
        vecs.push_back(mk(1, 1,4,0,0,0,0,0, 1,1,32'hB3,       1,13,32'hDD,       0,0,0,0,0,0));
        vecs.push_back(mk(0, 1,4,0,0,0,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        // Flush blocks the scoreboard set.
        vecs.push_back(mk(0, 1,0,0,9,1,1,1, 0,0,0,            0,0,0,             1,0,0,0,0,1));
        vecs.push_back(mk(0, 1,9,9,9,1,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        // Flush leaves existing pending bits alone.
        vecs.push_back(mk(0, 1,0,0,14,1,1,0, 0,0,0,           0,0,0,             1,0,0,0,0,0));
        vecs.push_back(mk(0, 1,14,0,0,0,0,1, 0,0,0,           0,0,0,             1,1,0,0,0,1));
        vecs.push_back(mk(0, 1,14,0,0,0,0,0, 0,0,0,           1,14,32'hE0E0E0E0, 1,1,0,0,0,0));
        vecs.push_back(mk(0, 1,14,0,0,0,0,0, 0,0,0,           0,0,0,             1,1,1,14,32'hE0E0E0E0,0));
        vecs.push_back(mk(0, 1,14,0,0,0,0,0, 0,0,0,           0,0,0,             1,0,0,0,0,0));
        // Multi-cycle to reg0 never marks a pending bit.
        vecs.push_back(mk(0, 1,0,0,0,1,1,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));
        vecs.push_back(mk(0, 1,0,0,0,1,0,0, 0,0,0,            0,0,0,             1,0,0,0,0,0));

        idle = mk(0, 0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0);
        apply(vecs[0]);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
            @(negedge clk);
            check_vec(i, vecs[i]);
        end

        // Hand-written: dst 12 result arrives while the port is busy with
        // pipeline writes; wait (bounded) for the deferred write.
        @(posedge clk); #1;
        apply(mk(0, 1,0,0,12,1,1,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        @(posedge clk); #1;
        apply(mk(0, 0,0,0,0,0,0,0, 1,1,32'hC1, 1,12,32'hC0FFEE00, 0,0,0,0,0,0));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            apply(mk(0, 1,12,0,0,0,0,0, 1,2,32'hC2, 0,0,0, 0,0,0,0,0,0));
            @(negedge clk);
            applied++;
            check($sformatf("seq.busy%0d.rb_addr_d", k), DW'(rb_addr_d), DW'(2));
        end
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            apply(mk(0, 1,12,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
            @(negedge clk);
            if (rb_we && rb_addr_d == AW'(12)) begin
                found = 1'b1;
                break;
            end
        end
        applied++;
        check("seq.deferred_write_seen", DW'(found), DW'(1));
        applied++;
        check("seq.deferred_write_data", rb_data_d, 32'hC0FFEE00);
        check("seq.stall_in_write_cycle", DW'(stall_issue), DW'(1));
        @(posedge clk); #1;
        apply(mk(0, 1,12,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        applied++;
        check("seq.stall_released", DW'(stall_issue), DW'(0));
        check("seq.port_idle", DW'(rb_we), DW'(0));

        @(posedge clk); #1;
        apply(idle);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule : tb_regbank_wb_scheduler

// File: doc/regbank_wb_scheduler.md
Name: regbank_wb_scheduler

Overview:
Controls access to the CPU register bank: 16 x 32-bit, reg0 hard-wired to zero, one write port, hold/clear inputs.
- Keeps a scoreboard of destination registers owned by in-flight multi-cycle ops (divider, slow loads).
- Stalls decode on RAW/WAW hazards against those registers.
- Shares the single write port between pipeline writeback and multi-cycle completions, which wait in a small FIFO.
- Sits between decode/writeback and the register bank, and drives the bank's we/addr_d/data_d/hold/clear.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 4, register address width (2^ADDR_W registers)
- FIFO_DEPTH, 2, multi-cycle result buffer entries (power of 2, >=2)
- PERF_W, 32, perf counter width (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_addr_a  in  ADDR_W  source A register
- id_addr_b  in  ADDR_W  source B register
- id_dst  in  ADDR_W  destination register
- id_dst_we  in  1  instruction writes id_dst
- id_multicycle  in  1  result returns later via mc_* port
- flush  in  1  pipeline flush (branch/interrupt)
- wb_we  in  1  pipeline writeback request; never stalled
- wb_addr  in  ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- mc_valid  in  1  multi-cycle result valid
- mc_addr  in  ADDR_W  multi-cycle result address
- mc_data  in  DATA_W  multi-cycle result data
- mc_ready  out  1  FIFO can accept a result
- stall_issue  out  1  decode must hold
- rb_we  out  1  to register bank we
- rb_addr_d  out  ADDR_W  to register bank addr_d
- rb_data_d  out  DATA_W  to register bank data_d
- rb_hold  out  1  to register bank hold
- rb_clear  out  1  to register bank clear

Behaviour:
- Reset: synchronous, active-high; clock clk. Scoreboard = 0, FIFO empty; every output = 0 while reset is high.
- Scoreboard: pending[2^ADDR_W] registered bits; bit 0 is never set.
- stall_issue (combinational from registered state) = id_valid & (pending[id_addr_a] | pending[id_addr_b] | (id_dst_we & pending[id_dst])).
  - A pending bit cleared in cycle N still stalls in cycle N; issue proceeds in N+1.
- Set: id_valid & !stall_issue & !flush & id_dst_we & id_multicycle & id_dst!=0 -> pending[id_dst] <= 1 next edge.
- mc handshake:
  - Accept when mc_valid & mc_ready.
  - mc_ready = !full; it deliberately does not look ahead at the same-cycle pop.
  - mc_addr==0 is accepted and discarded: no FIFO entry, no write.
- Write-port arbitration, fixed priority:
  - wb_we=1: rb_we=1, rb_addr_d=wb_addr, rb_data_d=wb_data.
  - Else if FIFO non-empty: drive head, rb_we=1, pop at edge, clear pending[head addr] at the same edge.
  - Else rb_we=0, rb_addr_d=0, rb_data_d=0.
- Write path timing: combinational mux. The register bank's own same-cycle write-to-read bypass covers forwarding; this block adds zero latency.
- Simultaneous push and pop on a full FIFO: push refused (mc_ready=0), pop proceeds.
- FIFO pointers: wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
- rb_hold = stall_issue; rb_clear = flush.
- flush: does not clear the scoreboard (in-flight multi-cycle ops still complete and write) and blocks scoreboard set that cycle.
- Pipeline writes to a pending register are illegal. The WAW stall prevents them; a simulation assertion flags wb_we with pending[wb_addr].
- Reset mid-operation: FIFO contents and pending bits are dropped; no write occurs in the reset cycle.

Optional Feature:
- Macro: REGBANK_SCHED_PERF_EN.
- Defined: adds outputs perf_stall_cycles[PERF_W] and perf_port_conflicts[PERF_W].
  - perf_stall_cycles counts cycles with stall_issue=1.
  - perf_port_conflicts counts cycles with wb_we=1 and FIFO non-empty.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package regbank_pkg: DATA_W/ADDR_W constants, REG_ZERO address constant, typedef for the FIFO entry {addr, data}.
- One sub-module regbank_sched_fifo: FIFO_DEPTH entries, push/pop/full/empty/count.
- Scoreboard, hazard logic and arbitration stay in the top module.

Test Plan:
- Issue multicycle id_dst=5; next cycle id_addr_a=5 -> stall_issue=1 until mc result (addr 5, 0xDEADBEEF) is written. rb_we=1/addr 5/data 0xDEADBEEF in write cycle; stall drops the cycle after.
- mc_valid addr 3 and wb_we addr 7 same cycle -> cycle 1 writes reg7 (wb data); cycle 2 writes reg3; pending[3] clears at end of cycle 2.
- Hold wb_we=1 for 4 cycles while pushing 3 mc results -> mc_ready=0 after 2 accepts. Third held until pop; FIFO drains in order after wb_we drops.
- mc_addr=0 with data 0x1234 -> accepted, rb_we stays 0, FIFO count unchanged.
- Issue multicycle dst=9 with flush=1 -> pending[9] stays 0, rb_clear=1, no stall next cycle.
- Assert reset with FIFO holding 2 entries and pending[4]=1 -> next cycle all outputs 0, mc_ready=1 after reset release, no stale write.
